// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared widths and FSM state encoding for the program loader.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN adds the CKSUM state.
package program_loader_pkg;
  localparam int INST_W = 16;
  localparam int ADDR_W = 4;
  localparam int BYTE_W = 8;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    WRITE = 3'd3,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    CKSUM = 3'd4,
`endif
    DONE  = 3'd5
  } state_t;
endpackage

// File: rtl/program_loader_word_assembler.sv
// word_assembler: latches high then low byte and presents the assembled instruction word.
// Ports: clk, rst_n (sync, active-low), hi_en/lo_en byte strobes, byte_data in,
// wr_data out (updated only when the low byte lands, so it holds between writes).
module word_assembler
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hi_en,
  input  logic              lo_en,
  input  logic [BYTE_W-1:0] byte_data,
  output logic [INST_W-1:0] wr_data
);
  logic [BYTE_W-1:0] hi_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q    <= '0;
      wr_data <= '0;
    end else begin
      if (hi_en) hi_q <= byte_data;
      if (lo_en) wr_data <= {hi_q, byte_data};
    end
  end
endmodule

// File: rtl/program_loader.sv
// program_loader: loads NUM_WORDS 16-bit words from a byte stream into program memory.
// Ports: clk, rst_n (sync, active-low), load_start, byte_valid/byte_data/byte_ready
// handshake, wr_en/wr_addr/wr_data memory write port, cpu_hold, load_done, load_error.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN (trailing checksum byte, load_error).
module program_loader
  import program_loader_pkg::*;
#(
  parameter int NUM_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [INST_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);
  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [BYTE_W-1:0] sum;
  logic              xfer, last, start;
  assign xfer  = byte_valid & byte_ready;
  assign last  = cnt == ADDR_W'(NUM_WORDS - 1);
  assign start = state == IDLE && load_start;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = load_start ? HI : IDLE;
      HI:      state_nx = xfer ? LO : HI;
      LO:      state_nx = xfer ? WRITE : LO;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      WRITE:   state_nx = last ? CKSUM : HI;
      CKSUM:   state_nx = xfer ? DONE : CKSUM;
`else
      WRITE:   state_nx = last ? DONE : HI;
`endif
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    byte_ready = state inside {HI, LO, CKSUM};
`else
    byte_ready = state inside {HI, LO};
`endif
    wr_en     = state == WRITE;
    cpu_hold  = state != IDLE;
    load_done = state == DONE;
  end
  // wr_addr is captured with the low byte so it is valid during WRITE and holds afterwards
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      sum     <= '0;
      wr_addr <= '0;
    end else begin
      if (start) begin
        cnt <= '0;
        sum <= '0;
      end
      if (xfer && (state == HI || state == LO)) sum <= sum + byte_data;
      if (xfer && state == LO) wr_addr <= cnt;
      if (state == WRITE && !last) cnt <= cnt + 1'b1;
    end
  end
  word_assembler u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .hi_en    (xfer && state == HI),
    .lo_en    (xfer && state == LO),
    .byte_data(byte_data),
    .wr_data  (wr_data)
  );
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] ck;
  assign ck = sum + byte_data;
  always_ff @(posedge clk) begin
    if (!rst_n || start) load_error <= 1'b0;
    else if (state == CKSUM && xfer) load_error <= ck != '0;
  end
`else
  assign load_error = 1'b0;
`endif
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed scoreboard bench for program_loader (NUM_WORDS=16).
module tb_program_loader;
  logic        clk = 1'b0, rst_n = 1'b0, load_start = 1'b0, byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, wr_en, cpu_hold, load_done, load_error;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  program_loader #(.NUM_WORDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
  );
  always #5 clk = ~clk;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  int vecs = 0, errs = 0, cyc = 0, done_cnt = 0, t0 = 0, d0 = 0;
  logic [19:0] exp_q[$];
  logic [7:0]  sum_m;
  logic [15:0] prog[16];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (load_done) done_cnt++;
    if (wr_en) begin
      check("write_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("wr_addr_data", {12'h0, wr_addr, wr_data}, {12'h0, exp_q.pop_front()});
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_data  = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("ready_timeout", 32'(byte_ready), 1);
    tick();
    sum_m = sum_m + b;
  endtask
  task automatic send_word(input int a, input logic [15:0] d);
    send_byte(d[15:8]);
    exp_q.push_back({4'(a), d});
    send_byte(d[7:0]);
  endtask
  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    sum_m = '0;
    t0 = cyc - 1;
    d0 = done_cnt;
    check("hold_after_start", 32'(cpu_hold), 1);
    check("err_cleared_on_start", 32'(load_error), 0);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {27'h0, byte_ready, wr_en, cpu_hold, load_done, load_error}, 0);
    check({tag, "_addr"}, 32'(wr_addr), 0);
    check({tag, "_data"}, 32'(wr_data), 0);
  endtask
  task automatic finish(input bit bad, input bit timed);
    int n = 0;
    logic e;
    e = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    e = bad;
    send_byte(8'(8'h00 - sum_m) ^ {7'h0, bad});
`endif
    byte_valid = 1'b0;
    while (!load_done && n < 10) begin
      tick();
      n++;
    end
    check("done_seen", 32'(load_done), 1);
    if (timed) check("session_len", cyc - t0 + 1, 16 * 3 + 2 + CK);
    check("done_err", 32'(load_error), 32'(e));
    check("done_hold", 32'(cpu_hold), 1);
    tick();
    check("hold_release", 32'(cpu_hold), 0);
    check("done_one_cycle", 32'(load_done), 0);
    check("err_after_done", 32'(load_error), 32'(e));
    check("one_done_pulse", done_cnt - d0, 1);
    check("queue_drained", exp_q.size(), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();
    check("idle_ready", 32'(byte_ready), 0);
    check("idle_hold", 32'(cpu_hold), 0);
    prog[0] = 16'h1E07;
    prog[1] = 16'hFE00;
    for (int i = 2; i < 16; i++) prog[i] = 16'($urandom);
    start();
    for (int i = 0; i < 16; i++) send_word(i, prog[i]);
    finish(1'b0, 1'b1);
    tick();
    tick();
    check("addr_hold", 32'(wr_addr), 15);
    check("data_hold", 32'(wr_data), 32'(prog[15]));
    start();
    send_byte(8'hA5);
    byte_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_ready", 32'(byte_ready), 1);
      check("stall_no_wr", 32'(wr_en), 0);
      tick();
    end
    exp_q.push_back({4'd0, 16'hA55A});
    send_byte(8'h5A);
    send_byte(8'h3C);
    load_start = 1'b1;
    byte_valid = 1'b0;
    tick();
    load_start = 1'b0;
    check("ls_in_lo_ready", 32'(byte_ready), 1);
    check("ls_in_lo_hold", 32'(cpu_hold), 1);
    exp_q.push_back({4'd1, 16'h3C00});
    send_byte(8'h00);
    for (int i = 2; i < 16; i++) send_word(i, 16'($urandom));
    finish(1'b1, 1'b0);
    tick();
    tick();
    check("err_sticky", 32'(load_error), CK);
    start();
    for (int i = 0; i < 3; i++) send_word(i, 16'($urandom));
    send_byte(8'h77);
    byte_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check_zero("abort");
    rst_n = 1'b1;
    tick();
    tick();
    check("abort_no_wr", 32'(wr_en), 0);
    start();
    for (int i = 0; i < 16; i++) send_word(i, prog[15 - i] ^ 16'h5AA5);
    finish(1'b0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter NUM_WORDS, default 16: number of 16-bit instruction words loaded per session; legal range 1..16.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 load_start  input  1  single-cycle request to begin a load session.
REQ-005 byte_valid  input  1  source presents byte_data.
REQ-006 byte_data  input  8  serial program byte; high byte of each word first.
REQ-007 byte_ready  output  1  loader accepts byte; transfer occurs when byte_valid and byte_ready are both 1 on a rising edge.
REQ-008 wr_en  output  1  single-cycle write strobe to the program memory.
REQ-009 wr_addr  output  4  instruction memory word address.
REQ-010 wr_data  output  16  instruction word, {high_byte, low_byte}.
REQ-011 cpu_hold  output  1  holds the processor in reset while a session is active.
REQ-012 load_done  output  1  one-cycle pulse at session end.
REQ-013 load_error  output  1  sticky checksum-mismatch flag; cleared by the next accepted load_start.

Function
REQ-014 States: IDLE, HI, LO, WRITE, CKSUM, DONE.
REQ-015 IDLE: byte_ready=0, cpu_hold=0; load_start=1 -> HI, address counter=0, running sum=0, load_error=0.
REQ-016 load_start in any state other than IDLE shall be ignored.
REQ-017 HI: byte_ready=1; on transfer latch high byte, add it to the sum -> LO; no transfer -> stay in HI.
REQ-018 LO: byte_ready=1; on transfer latch low byte, add it to the sum -> WRITE.
REQ-019 WRITE: byte_ready=0, wr_en=1 for exactly one cycle, wr_addr=counter, wr_data={high,low}.
REQ-020 WRITE exit: if counter==NUM_WORDS-1 -> CKSUM (macro defined) or DONE (macro undefined); otherwise counter+1 -> HI.
REQ-021 The address counter shall never wrap; the last write is at NUM_WORDS-1.
REQ-022 DONE: load_done=1 for one cycle -> IDLE; cpu_hold=1 from the cycle after load_start through DONE inclusive, and 0 in the following cycle.
REQ-023 Minimum session length: NUM_WORDS*3 + 2 cycles with byte_valid held at 1 (plus 1 cycle when the checksum is enabled).
REQ-024 Running sum: 8-bit, modulo 256.
REQ-025 wr_addr and wr_data shall hold their last values when wr_en=0.

Reset
REQ-026 rst_n=0 at a rising edge shall force IDLE, counter=0, sum=0, and all outputs to 0, including while a session is active; no partial write shall be issued.

Configuration
REQ-027 PROGRAM_LOADER_CHECKSUM_EN defined: CKSUM state present; byte_ready=1; accepts one byte; load_error=1 if (sum+byte) mod 256 != 0 -> DONE.
REQ-028 PROGRAM_LOADER_CHECKSUM_EN undefined: no CKSUM state; load_error tied to 0; WRITE of the last word -> DONE.

Structure
REQ-029 Shared package: state encoding, INST_W=16, ADDR_W=4, BYTE_W=8.
REQ-030 One sub-module, word_assembler: latches the high and low bytes and produces wr_data.

Verification
REQ-031 Checksum undefined, NUM_WORDS=2, bytes 1E 07 FE 00 with byte_valid held at 1 -> wr 0:1E07, wr 1:FE00, load_done pulse, cpu_hold falls the cycle after.
REQ-032 Checksum defined, NUM_WORDS=1, bytes 1E 07 DB -> wr 0:1E07, load_error=0; repeat with checksum byte DA -> load_error=1 and held until the next load_start.
REQ-033 byte_valid deasserted for 5 cycles between the high and low byte -> state held, byte_ready=1, no wr_en, write completes after resume.
REQ-034 rst_n=0 after the high byte of word 3 -> outputs 0, next load_start restarts at wr_addr 0.
REQ-035 load_start pulsed in LO -> ignored; counter and bytes unaffected.
REQ-036 NUM_WORDS=16 full load -> 16 writes at addresses 0..15, no write beyond 15, exactly one load_done pulse.
